sprite_blit_writer: RTL
=======================

# sprite_blit_writer

Sequential sprite copier that walks a rectangular sprite in sprite ROM and writes each pixel into the 320x240 frame buffer at a requested screen position. It is the write-side counterpart of the static address generator. Pixels it places at (start_x, start_y) read back through the static address generator's mapping as the same sprite image. It sits between the game-logic scheduler (start/done handshake) and the frame-buffer BRAM write port.

## Interface
- SCREEN_W, 320, frame-buffer width in pixels
- SCREEN_H, 240, frame-buffer height in pixels
- PIX_W, 12, pixel width (RGB444)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a blit; sampled only in IDLE
- width  in  10  sprite width in pixels, latched on accepted start
- height  in  10  sprite height in pixels, latched on accepted start
- start_x  in  10  screen x origin, latched on accepted start
- start_y  in  10  screen y origin, latched on accepted start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the blit completes
- src_addr  out  17  sprite ROM read address (synchronous ROM, 1-cycle latency)
- src_data  in  PIX_W  sprite ROM read data
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  17  frame-buffer write address
- fb_data  out  PIX_W  frame-buffer write data (= src_data, combinational pass-through)

## Operation
- States: IDLE, READ, FLUSH, DONE.
- IDLE: start=1 latches geometry, sets r=0, c=1, and goes to READ. If width==0 or height==0, goes to DONE instead and performs no writes.
- READ: src_addr = r*width + c, with c in 1..width and r in 0..height-1. This is the same column-from-1 mapping the static address generator uses.
  - Each cycle, c increments; after c==width, c resets to 1 and r increments.
  - The issuing cycle's target x=start_x+c and y=start_y+r are registered into the write stage.
  - After the (width, height-1) issue, go to FLUSH.
- FLUSH: the final write stage drains, then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- Write stage: in the cycle after an issue, fb_addr = y*SCREEN_W + x and fb_we=1, unless x>=SCREEN_W or y>=SCREEN_H. Clipped pixels are still iterated but not written.
- Arithmetic widths:
  - x and y sums use 11 bits, so no wrap before the clip compare.
  - Multiplies produce at least 17 bits, truncated to 17 only after the clip check.
- start during busy is ignored. Geometry input changes during busy have no effect.

## Timing
- Reset values: busy=0, done=0, fb_we=0, fb_addr=0, src_addr=0, state=IDLE.
- Cycle numbering: start accepted at cycle 0, N=width*height.
  - Issues occur on cycles 1..N.
  - Writes occur on cycles 2..N+1.
  - FLUSH is cycle N+1.
  - done pulses on cycle N+2.
- Zero-size blit: done pulses on cycle 1, fb_we is never asserted.
- fb_we has at most one pulse per cycle and never asserts outside busy.
- Asynchronous reset mid-blit: all outputs go to reset values immediately and state goes to IDLE. Already-written pixels remain, and no done pulse occurs.
- start asserted on the DONE cycle is ignored. It is accepted on the following IDLE cycle.

## Configuration
- TRANSPARENT_EN defined: a write whose src_data equals TRANSPARENT_COLOR is suppressed (fb_we=0). Iteration and timing are unchanged.
- TRANSPARENT_EN undefined: every in-screen pixel is written regardless of color.

## Structure
- The shared package doodle_gfx_pkg holds:
  - SCREEN_W, SCREEN_H, PIX_W
  - ADDR_W=17
  - TRANSPARENT_COLOR=12'h000
  - the blit state enum
- Sub-module blit_addr_calc: combinational (x, y) -> fb_addr plus clip flag. It is instantiated once in the write stage.

## Test plan
- Basic blit: width=4, height=2, start_x=10, start_y=5.
  - Expect 8 writes on cycles 2..9.
  - First write: fb_addr=5*320+11=1611, src_addr 1.
  - Last write: fb_addr=6*320+14=1934, src_addr 8.
  - done on cycle 10.
- Right/bottom clip: width=8, height=4, start_x=316, start_y=238.
  - Only x in 317..319 and y in 238..239 are written: 6 writes.
  - done still on cycle 34.
- Zero size: width=0, height=7 -> no fb_we, done on cycle 1, busy never high.
- Start while busy: a second start pulse during a 16-pixel blit is ignored. Exactly 16 writes, one done.
- Async reset: rst_n low at cycle 5 of a 4x4 blit.
  - busy=0 and fb_we=0 immediately.
  - No done.
  - A new start after release runs normally.
- TRANSPARENT_EN: a 2x2 sprite whose ROM data is {12'h000, 12'hF00, 12'h000, 12'h0F0} produces 2 writes, with data F00 and 0F0. The same sprite without the macro produces 4 writes.

Source files
------------

// File: rtl/doodle_gfx_pkg.sv
// ----------------------------------------------------------------------------
// doodle_gfx_pkg
// Shared constants and types for the doodle graphics blocks.
//   SCREEN_W / SCREEN_H : frame-buffer geometry in pixels
//   PIX_W               : pixel width (RGB444)
//   ADDR_W              : frame-buffer / sprite ROM address width
//   DIM_W               : width of sprite dimensions and screen origins
//   COORD_W             : width of computed screen coordinates (origin + offset)
//   TRANSPARENT_COLOR   : colour key used when transparency is compiled in
//   blit_state_e        : sprite blit FSM states
// ----------------------------------------------------------------------------
package doodle_gfx_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned PIX_W    = 12;
  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DIM_W    = 10;
  // One extra bit so origin + offset can never wrap back on screen.
  localparam int unsigned COORD_W  = DIM_W + 1;

  localparam logic [PIX_W-1:0] TRANSPARENT_COLOR = 12'h000;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StFlush,
    StDone
  } blit_state_e;

endpackage

// File: rtl/sprite_blit_writer_if.sv
// ----------------------------------------------------------------------------
// sprite_blit_writer_if
// Bundles the scheduler handshake, the sprite ROM read port and the
// frame-buffer write port of sprite_blit_writer.
//   start/width/height/start_x/start_y : blit request and geometry
//   busy/done                          : blit status back to the scheduler
//   src_addr/src_data                  : sprite ROM read (1-cycle latency)
//   fb_we/fb_addr/fb_data              : frame-buffer write port
// Modports:
//   master : environment side (scheduler, sprite ROM, frame buffer)
//   slave  : the blitter itself
// ----------------------------------------------------------------------------
interface sprite_blit_writer_if;
  import doodle_gfx_pkg::*;

  logic               start;
  logic [DIM_W-1:0]   width;
  logic [DIM_W-1:0]   height;
  logic [DIM_W-1:0]   start_x;
  logic [DIM_W-1:0]   start_y;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  src_addr;
  logic [PIX_W-1:0]   src_data;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [PIX_W-1:0]   fb_data;

  // The environment also plays the sprite ROM, so it drives src_data.
  modport master (
    output start, width, height, start_x, start_y, src_data,
    input  busy, done, src_addr, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  start, width, height, start_x, start_y, src_data,
    output busy, done, src_addr, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/blit_addr_calc.sv
// ----------------------------------------------------------------------------
// blit_addr_calc
// Combinational screen coordinate to frame-buffer address mapping with clip.
//   i_x, i_y : screen coordinates (COORD_W bits, never wrapped)
//   o_addr   : y * SCREEN_W + x, truncated to ADDR_W bits
//   o_clip   : coordinate lies outside the visible frame buffer
// ----------------------------------------------------------------------------
module blit_addr_calc
  import doodle_gfx_pkg::*;
(
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_clip
);

  // Wide enough for the largest coordinate pair: 2046 * 320 + 2046.
  localparam int unsigned ProdW = 20;

  logic [ProdW-1:0] w_lin;
  logic             w_off_screen;

  assign w_lin        = ProdW'(i_y) * ProdW'(SCREEN_W) + ProdW'(i_x);
  assign w_off_screen = (i_x >= COORD_W'(SCREEN_W)) || (i_y >= COORD_W'(SCREEN_H));

  // An on-screen pixel never reaches bit ADDR_W, so folding the high bits
  // into the clip flag changes nothing for valid pixels and guarantees a
  // truncated address can never alias onto the screen.
  assign o_clip = w_off_screen || (|w_lin[ProdW-1:ADDR_W]);
  assign o_addr = w_lin[ADDR_W-1:0];

endmodule

// File: rtl/sprite_blit_writer.sv
// ----------------------------------------------------------------------------
// sprite_blit_writer
// Walks a width x height sprite in sprite ROM and writes every pixel into the
// 320x240 frame buffer with its top-left at (start_x, start_y). Sprite pixel
// (r, c) is read from ROM address r*width + c with c counting from 1, matching
// the static address generator, and lands at screen (start_x+c, start_y+r).
// Off-screen pixels are iterated but not written.
//
// Ports:
//   clk    : system clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : sprite_blit_writer_if.slave (handshake, ROM read, FB write)
//
// Build option:
//   TRANSPARENT_EN : when defined, pixels whose ROM data equals
//                    TRANSPARENT_COLOR are not written; timing is unchanged.
//
// Timing (start accepted in cycle 0, N = width*height):
//   issues on cycles 1..N, writes on cycles 2..N+1, FLUSH on N+1,
//   done pulse on N+2. Zero-size blits pulse done on cycle 1.
// ----------------------------------------------------------------------------
module sprite_blit_writer
  import doodle_gfx_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  sprite_blit_writer_if.slave io_bus
);

  blit_state_e        r_state;
  logic [DIM_W-1:0]   r_width;
  logic [DIM_W-1:0]   r_height;
  logic [DIM_W-1:0]   r_sx;
  logic [DIM_W-1:0]   r_sy;
  logic [DIM_W-1:0]   r_c;
  logic [DIM_W-1:0]   r_r;
  logic [ADDR_W-1:0]  r_src_addr;
  logic               r_busy;
  logic               r_done;

  // Write stage: target coordinate of the previous cycle's issue.
  logic               r_wvalid;
  logic [COORD_W-1:0] r_wx;
  logic [COORD_W-1:0] r_wy;

  logic               w_zero_size;
  logic               w_row_end;
  logic               w_last_issue;
  logic               w_clip;
  logic               w_transparent;
  logic [ADDR_W-1:0]  w_fb_addr;

  assign w_zero_size  = (io_bus.width == '0) || (io_bus.height == '0);
  assign w_row_end    = (r_c == r_width);
  assign w_last_issue = w_row_end && (r_r == r_height - DIM_W'(1));

  // --------------------------------------------------------------------------
  // Control FSM and issue stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_width    <= '0;
      r_height   <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_c        <= '0;
      r_r        <= '0;
      r_src_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wvalid   <= 1'b0;
      r_wx       <= '0;
      r_wy       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_width  <= io_bus.width;
            r_height <= io_bus.height;
            r_sx     <= io_bus.start_x;
            r_sy     <= io_bus.start_y;
            r_r      <= '0;
            r_c      <= DIM_W'(1);
            if (w_zero_size) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state    <= StRead;
              r_busy     <= 1'b1;
              r_src_addr <= ADDR_W'(1);
            end
          end
        end

        StRead: begin
          r_wvalid <= 1'b1;
          r_wx     <= COORD_W'(r_sx) + COORD_W'(r_c);
          r_wy     <= COORD_W'(r_sy) + COORD_W'(r_r);
          if (w_last_issue) begin
            r_state <= StFlush;
          end else begin
            // r*width + c advances by exactly one, including across a row
            // wrap, so the ROM address is a plain counter.
            r_src_addr <= r_src_addr + ADDR_W'(1);
            if (w_row_end) begin
              r_c <= DIM_W'(1);
              r_r <= r_r + DIM_W'(1);
            end else begin
              r_c <= r_c + DIM_W'(1);
            end
          end
        end

        StFlush: begin
          r_wvalid <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= StDone;
        end

        StDone: begin
          // start is deliberately not sampled here.
          r_done  <= 1'b0;
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write stage
  // --------------------------------------------------------------------------
  blit_addr_calc u_addr_calc (
    .i_x    (r_wx),
    .i_y    (r_wy),
    .o_addr (w_fb_addr),
    .o_clip (w_clip)
  );

`ifdef TRANSPARENT_EN
  // ROM data for the issue arrives in the write cycle, aligned with r_wvalid.
  assign w_transparent = (io_bus.src_data == TRANSPARENT_COLOR);
`else
  assign w_transparent = 1'b0;
`endif

  assign io_bus.fb_we    = r_wvalid && !w_clip && !w_transparent;
  assign io_bus.fb_addr  = w_fb_addr;
  assign io_bus.fb_data  = io_bus.src_data;
  assign io_bus.src_addr = r_src_addr;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;

endmodule
